// File: rtl/cprv_pkg.sv
// Shared RISC-V decode definitions: base opcodes, immediate formats and the
// control bundle carried from ID into EX.
package cprv_pkg;

    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic       rd_en;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       illegal;
    } ex_ctrl_t;

endpackage

// File: rtl/cprv_imm_gen.sv
// Combinational immediate generator: assembles the format-specific immediate
// from the instruction and sign-extends it to DATA_WIDTH.
module cprv_imm_gen
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [31:7]           instr_i,
    input  imm_type_e             imm_type_i,
    output logic [DATA_WIDTH-1:0] imm_o
);

    logic [31:0] imm32_s;

    // Build the 32-bit sign-extended immediate for the selected format.
    always_comb begin
        imm32_s = 32'd0;
        case (imm_type_i)
            IMM_I:   imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm32_s = {instr_i[31:12], 12'd0};
            IMM_J:   imm32_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    // Size cast of a signed value replicates bit 31 up to DATA_WIDTH.
    assign imm_o = DATA_WIDTH'($signed(imm32_s));

endmodule

// File: rtl/cprv_decode_stage.sv
// ID stage: decodes one instruction, reads/forwards operands, applies the
// load-use interlock and registers the result into the EX pipeline slot.
module cprv_decode_stage
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int INSTR_WIDTH    = 32,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   valid_id_i,
    output logic                   ready_id_o,
    input  logic [INSTR_WIDTH-1:0] instr_data_id_i,
    input  logic [DATA_WIDTH-1:0]  pc_id_i,
    output logic [4:0]             rs1_addr_rf_o,
    output logic [4:0]             rs2_addr_rf_o,
    input  logic [DATA_WIDTH-1:0]  rs1_data_rf_i,
    input  logic [DATA_WIDTH-1:0]  rs2_data_rf_i,
    input  logic                   wb_rd_en_i,
    input  logic [4:0]             wb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]  wb_rd_data_i,
    output logic                   valid_ex_o,
    input  logic                   ready_ex_i,
    output logic [DATA_WIDTH-1:0]  pc_ex_o,
    output logic [DATA_WIDTH-1:0]  rs1_data_ex_o,
    output logic [DATA_WIDTH-1:0]  rs2_data_ex_o,
    output logic [DATA_WIDTH-1:0]  imm_data_ex_o,
    output logic [4:0]             rd_addr_ex_o,
    output logic                   rd_en_ex_o,
    output logic [6:0]             opcode_ex_o,
    output logic [2:0]             funct3_ex_o,
    output logic [6:0]             funct7_ex_o,
    output logic                   mem_r_en_ex_o,
    output logic                   mem_w_en_ex_o,
    output logic                   illegal_ex_o
);

    localparam logic IS_RV64 = (DATA_WIDTH == 64);

    logic [31:0]           instr_s;
    logic [6:0]            opcode_s;
    logic [4:0]            rs1_addr_s;
    logic [4:0]            rs2_addr_s;
    logic [4:0]            rd_addr_s;
    imm_type_e             imm_type_s;
    logic                  known_s;
    logic                  word_op_s;
    logic                  writes_rd_s;
    logic                  rs1_used_s;
    logic                  rs2_used_s;
    logic                  illegal_s;
    ex_ctrl_t              ctrl_dec_s;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] rs1_op_s;
    logic [DATA_WIDTH-1:0] rs2_op_s;
    logic                  cke_s;
    logic                  hazard_s;
    logic                  stall_s;

    logic                  valid_ex_d, valid_ex_q;
    logic [DATA_WIDTH-1:0] pc_ex_d, pc_ex_q;
    logic [DATA_WIDTH-1:0] rs1_ex_d, rs1_ex_q;
    logic [DATA_WIDTH-1:0] rs2_ex_d, rs2_ex_q;
    logic [DATA_WIDTH-1:0] imm_ex_d, imm_ex_q;
    ex_ctrl_t              ctrl_ex_d, ctrl_ex_q;

    function automatic logic [DATA_WIDTH-1:0] sel_operand(
        input logic [4:0]            addr,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  wb_en,
        input logic [4:0]            wb_addr,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        if (addr == 5'd0) begin
            return '0;
        end else if (wb_en && (wb_addr == addr)) begin
            return wb_data;
        end else begin
            return rf_data;
        end
    endfunction

    assign instr_s    = instr_data_id_i[31:0];
    assign opcode_s   = instr_s[6:0];
    assign rd_addr_s  = instr_s[11:7];
    assign rs1_addr_s = instr_s[19:15];
    assign rs2_addr_s = instr_s[24:20];

    assign rs1_addr_rf_o = rs1_addr_s;
    assign rs2_addr_rf_o = rs2_addr_s;

    // Opcode classification: format, destination write and source usage.
    always_comb begin
        known_s     = 1'b1;
        word_op_s   = 1'b0;
        writes_rd_s = 1'b0;
        rs1_used_s  = 1'b0;
        rs2_used_s  = 1'b0;
        imm_type_s  = IMM_NONE;
        case (opcode_s)
            LUI, AUIPC: begin writes_rd_s = 1'b1; imm_type_s = IMM_U; end
            JAL:        begin writes_rd_s = 1'b1; imm_type_s = IMM_J; end
            JALR:       begin writes_rd_s = 1'b1; rs1_used_s = 1'b1; imm_type_s = IMM_I; end
            BRANCH:     begin rs1_used_s = 1'b1; rs2_used_s = 1'b1; imm_type_s = IMM_B; end
            LOAD:       begin writes_rd_s = 1'b1; rs1_used_s = 1'b1; imm_type_s = IMM_I; end
            STORE:      begin rs1_used_s = 1'b1; rs2_used_s = 1'b1; imm_type_s = IMM_S; end
            OP_IMM:     begin writes_rd_s = 1'b1; rs1_used_s = 1'b1; imm_type_s = IMM_I; end
            OP:         begin writes_rd_s = 1'b1; rs1_used_s = 1'b1; rs2_used_s = 1'b1; end
            OP_IMM_32: begin
                writes_rd_s = 1'b1; rs1_used_s = 1'b1; word_op_s = 1'b1; imm_type_s = IMM_I;
            end
            OP_32: begin
                writes_rd_s = 1'b1; rs1_used_s = 1'b1; rs2_used_s = 1'b1; word_op_s = 1'b1;
            end
            default:    known_s = 1'b0;
        endcase
    end

    // Word-sized ops only exist on RV64; illegal instructions have no side effects.
    assign illegal_s = ~known_s | (word_op_s & ~IS_RV64);

    // Control bundle handed to EX.
    always_comb begin
        ctrl_dec_s          = '0;
        ctrl_dec_s.rd_addr  = rd_addr_s;
        ctrl_dec_s.rd_en    = writes_rd_s & ~illegal_s & (rd_addr_s != 5'd0);
        ctrl_dec_s.opcode   = opcode_s;
        ctrl_dec_s.funct3   = instr_s[14:12];
        ctrl_dec_s.funct7   = instr_s[31:25];
        ctrl_dec_s.mem_r_en = (opcode_s == LOAD) & ~illegal_s;
        ctrl_dec_s.mem_w_en = (opcode_s == STORE) & ~illegal_s;
        ctrl_dec_s.illegal  = illegal_s;
    end

    cprv_imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .instr_i    (instr_s[31:7]),
        .imm_type_i (imm_type_s),
        .imm_o      (imm_s)
    );

    assign rs1_op_s = sel_operand(rs1_addr_s, rs1_data_rf_i, wb_rd_en_i, wb_rd_addr_i, wb_rd_data_i);
    assign rs2_op_s = sel_operand(rs2_addr_s, rs2_data_rf_i, wb_rd_en_i, wb_rd_addr_i, wb_rd_data_i);

    // Load-use hazard: the load in EX produces a register the ID instruction reads.
    always_comb begin
        if (valid_ex_q && ctrl_ex_q.mem_r_en && ctrl_ex_q.rd_en) begin
            hazard_s = (rs1_used_s && (rs1_addr_s == ctrl_ex_q.rd_addr)) ||
                       (rs2_used_s && (rs2_addr_s == ctrl_ex_q.rd_addr));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign cke_s      = ~valid_ex_q | ready_ex_i;
    assign stall_s    = (LOAD_USE_STALL != 0) & valid_id_i & hazard_s;
    assign ready_id_o = ~rst & (flush_i | (cke_s & ~stall_s));

    // EX slot next state: flush beats advance, advance beats hold.
    always_comb begin
        valid_ex_d = valid_ex_q;
        pc_ex_d    = pc_ex_q;
        rs1_ex_d   = rs1_ex_q;
        rs2_ex_d   = rs2_ex_q;
        imm_ex_d   = imm_ex_q;
        ctrl_ex_d  = ctrl_ex_q;
        if (flush_i) begin
            valid_ex_d = 1'b0;
        end else if (cke_s) begin
            valid_ex_d = valid_id_i & ~stall_s;
            pc_ex_d    = pc_id_i;
            rs1_ex_d   = rs1_op_s;
            rs2_ex_d   = rs2_op_s;
            imm_ex_d   = imm_s;
            ctrl_ex_d  = ctrl_dec_s;
        end else begin
            valid_ex_d = valid_ex_q;
        end
    end

    // EX pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_ex_q <= 1'b0;
            pc_ex_q    <= '0;
            rs1_ex_q   <= '0;
            rs2_ex_q   <= '0;
            imm_ex_q   <= '0;
            ctrl_ex_q  <= '0;
        end else begin
            valid_ex_q <= valid_ex_d;
            pc_ex_q    <= pc_ex_d;
            rs1_ex_q   <= rs1_ex_d;
            rs2_ex_q   <= rs2_ex_d;
            imm_ex_q   <= imm_ex_d;
            ctrl_ex_q  <= ctrl_ex_d;
        end
    end

    assign valid_ex_o    = valid_ex_q;
    assign pc_ex_o       = pc_ex_q;
    assign rs1_data_ex_o = rs1_ex_q;
    assign rs2_data_ex_o = rs2_ex_q;
    assign imm_data_ex_o = imm_ex_q;
    assign rd_addr_ex_o  = ctrl_ex_q.rd_addr;
    assign rd_en_ex_o    = ctrl_ex_q.rd_en;
    assign opcode_ex_o   = ctrl_ex_q.opcode;
    assign funct3_ex_o   = ctrl_ex_q.funct3;
    assign funct7_ex_o   = ctrl_ex_q.funct7;
    assign mem_r_en_ex_o = ctrl_ex_q.mem_r_en;
    assign mem_w_en_ex_o = ctrl_ex_q.mem_w_en;
    assign illegal_ex_o  = ctrl_ex_q.illegal;

endmodule

// File: tb/tb_cprv_decode_stage.sv
// Scoreboard bench: an RV64 interlocked instance and an RV32 non-interlocked
// instance share one stimulus stream and are checked against a reference model.
module tb_cprv_decode_stage;

    localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6F, T_JALR = 7'h67;
    localparam logic [6:0] T_BR  = 7'h63, T_LD = 7'h03, T_ST = 7'h23, T_OPI = 7'h13;
    localparam logic [6:0] T_OP  = 7'h33, T_OPIW = 7'h1B, T_OPW = 7'h3B;
    localparam logic [6:0] OPS [12] = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD,
                                        T_ST, T_OPI, T_OP, T_OPIW, T_OPW, 7'h73};
    localparam int DWS [2] = '{64, 32};
    localparam bit LUS [2] = '{1'b1, 1'b0};

    typedef struct packed {
        logic [63:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic        rd_en;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        mr, mw, ill;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, valid_id = 1'b0, ready_ex = 1'b0, wb_en = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [63:0] pc = 64'd0, rs1d = 64'd0, rs2d = 64'd0, wb_data = 64'd0;
    logic [4:0]  wb_addr = 5'd0;

    always #5 clk = ~clk;

    logic        rdy [2];
    logic        vex [2];
    logic [4:0]  rs1a [2];
    logic [4:0]  rs2a [2];
    ex_t         got [2];

    logic [63:0] d0_pc, d0_rs1, d0_rs2, d0_imm;
    logic [31:0] d1_pc, d1_rs1, d1_rs2, d1_imm;
    logic [4:0]  d0_rd, d1_rd;
    logic [6:0]  d0_op, d1_op, d0_f7, d1_f7;
    logic [2:0]  d0_f3, d1_f3;
    logic        d0_rden, d1_rden, d0_mr, d1_mr, d0_mw, d1_mw, d0_ill, d1_ill;

    cprv_decode_stage #(.DATA_WIDTH(64), .INSTR_WIDTH(32), .LOAD_USE_STALL(1)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush), .valid_id_i(valid_id), .ready_id_o(rdy[0]),
        .instr_data_id_i(instr), .pc_id_i(pc), .rs1_addr_rf_o(rs1a[0]), .rs2_addr_rf_o(rs2a[0]),
        .rs1_data_rf_i(rs1d), .rs2_data_rf_i(rs2d), .wb_rd_en_i(wb_en), .wb_rd_addr_i(wb_addr),
        .wb_rd_data_i(wb_data), .valid_ex_o(vex[0]), .ready_ex_i(ready_ex), .pc_ex_o(d0_pc),
        .rs1_data_ex_o(d0_rs1), .rs2_data_ex_o(d0_rs2), .imm_data_ex_o(d0_imm),
        .rd_addr_ex_o(d0_rd), .rd_en_ex_o(d0_rden), .opcode_ex_o(d0_op), .funct3_ex_o(d0_f3),
        .funct7_ex_o(d0_f7), .mem_r_en_ex_o(d0_mr), .mem_w_en_ex_o(d0_mw), .illegal_ex_o(d0_ill));

    cprv_decode_stage #(.DATA_WIDTH(32), .INSTR_WIDTH(32), .LOAD_USE_STALL(0)) dut32 (
        .clk(clk), .rst(rst), .flush_i(flush), .valid_id_i(valid_id), .ready_id_o(rdy[1]),
        .instr_data_id_i(instr), .pc_id_i(pc[31:0]), .rs1_addr_rf_o(rs1a[1]),
        .rs2_addr_rf_o(rs2a[1]), .rs1_data_rf_i(rs1d[31:0]), .rs2_data_rf_i(rs2d[31:0]),
        .wb_rd_en_i(wb_en), .wb_rd_addr_i(wb_addr), .wb_rd_data_i(wb_data[31:0]),
        .valid_ex_o(vex[1]), .ready_ex_i(ready_ex), .pc_ex_o(d1_pc),
        .rs1_data_ex_o(d1_rs1), .rs2_data_ex_o(d1_rs2), .imm_data_ex_o(d1_imm),
        .rd_addr_ex_o(d1_rd), .rd_en_ex_o(d1_rden), .opcode_ex_o(d1_op), .funct3_ex_o(d1_f3),
        .funct7_ex_o(d1_f7), .mem_r_en_ex_o(d1_mr), .mem_w_en_ex_o(d1_mw), .illegal_ex_o(d1_ill));

    assign got[0] = {d0_pc, d0_rs1, d0_rs2, d0_imm, d0_rd, d0_rden, d0_op, d0_f3, d0_f7,
                     d0_mr, d0_mw, d0_ill};
    assign got[1] = {32'd0, d1_pc, 32'd0, d1_rs1, 32'd0, d1_rs2, 32'd0, d1_imm, d1_rd, d1_rden,
                     d1_op, d1_f3, d1_f7, d1_mr, d1_mw, d1_ill};

    int checks = 0;
    int passed = 0;

    ex_t sbq [2][$];
    bit  m_valid [2] = '{1'b0, 1'b0};
    bit  m_nxt   [2] = '{1'b0, 1'b0};
    bit  m_push  [2] = '{1'b0, 1'b0};
    bit  m_drop  [2] = '{1'b0, 1'b0};
    bit  exp_rdy [2] = '{1'b0, 1'b0};
    ex_t m_new   [2];

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [63:0] src(input logic [4:0] a, input logic [63:0] rf,
                                        input logic we, input logic [4:0] wa,
                                        input logic [63:0] wd);
        if (a == 5'd0) return 64'd0;
        if (we && wa == a) return wd;
        return rf;
    endfunction

    // What the instruction should look like once it sits in EX.
    function automatic ex_t ref_ex(input logic [31:0] i, input int dw, input logic [63:0] pcv,
                                   input logic [63:0] r1, input logic [63:0] r2);
        ex_t         e;
        logic [6:0]  op;
        bit          known, word, ill, writes;
        longint      imm;
        logic [63:0] mask;
        logic [11:0] s;
        logic [12:0] b;
        logic [20:0] j;
        op     = i[6:0];
        mask   = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        known  = op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_OPI, T_OP,
                            T_OPIW, T_OPW};
        word   = op inside {T_OPIW, T_OPW};
        ill    = !known || (word && dw != 64);
        writes = op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_LD, T_OPI, T_OP, T_OPIW, T_OPW};
        s = {i[31:25], i[11:7]};
        b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (op)
            T_LD, T_OPI, T_OPIW, T_JALR: imm = $signed(i[31:20]);
            T_ST:                        imm = $signed(s);
            T_BR:                        imm = $signed(b);
            T_LUI, T_AUIPC:              imm = $signed({i[31:12], 12'h000});
            T_JAL:                       imm = $signed(j);
            default:                     imm = 0;
        endcase
        e.pc    = pcv & mask;
        e.rs1   = src(i[19:15], r1, wb_en, wb_addr, wb_data) & mask;
        e.rs2   = src(i[24:20], r2, wb_en, wb_addr, wb_data) & mask;
        e.imm   = 64'(imm) & mask;
        e.rd    = i[11:7];
        e.rd_en = writes && !ill && (i[11:7] != 5'd0);
        e.op    = op;
        e.f3    = i[14:12];
        e.f7    = i[31:25];
        e.mr    = (op == T_LD) && !ill;
        e.mw    = (op == T_ST) && !ill;
        e.ill   = ill;
        return e;
    endfunction

    // Predict handshake and the next EX occupant from the inputs just driven.
    task automatic model_step();
        bit u1, u2;
        u1 = instr[6:0] inside {T_JALR, T_BR, T_LD, T_ST, T_OPI, T_OP, T_OPIW, T_OPW};
        u2 = instr[6:0] inside {T_OP, T_OPW, T_ST, T_BR};
        for (int d = 0; d < 2; d++) begin
            bit  cke, hz, stall;
            ex_t cur;
            m_push[d] = 1'b0;
            m_drop[d] = 1'b0;
            if (rst) begin
                sbq[d].delete();
                m_valid[d] = 1'b0;
                m_nxt[d]   = 1'b0;
                exp_rdy[d] = 1'b0;
            end else begin
                cke = !m_valid[d] || ready_ex;
                hz  = 1'b0;
                if (m_valid[d] && sbq[d].size() > 0) begin
                    cur = sbq[d][0];
                    hz  = cur.mr && cur.rd_en && ((u1 && instr[19:15] == cur.rd) ||
                                                  (u2 && instr[24:20] == cur.rd));
                end
                stall      = LUS[d] && valid_id && hz;
                exp_rdy[d] = flush || (cke && !stall);
                if (flush) begin
                    m_nxt[d]  = 1'b0;
                    m_drop[d] = m_valid[d] && !ready_ex;
                end else if (cke) begin
                    m_nxt[d]  = valid_id && !stall;
                    m_push[d] = m_nxt[d];
                    m_new[d]  = ref_ex(instr, DWS[d], pc, rs1d, rs2d);
                end else begin
                    m_nxt[d] = m_valid[d];
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic v, input logic re,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [63:0] r1, input logic [63:0] r2);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (m_drop[d]) sbq[d].delete();
            if (m_push[d]) sbq[d].push_back(m_new[d]);
            m_valid[d] = m_nxt[d];
        end
        #1;
        rst = r; instr = ins; valid_id = v; ready_ex = re; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd; rs1d = r1; rs2d = r2;
        pc = {$urandom, $urandom};
        model_step();
    endtask

    // Monitor: compare handshake every cycle and the EX contents against the queue head.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("ready_id", 288'(rdy[d]), 288'(exp_rdy[d]));
            chk("valid_ex", 288'(vex[d]), 288'(m_valid[d]));
            chk("rs1_addr", 288'(rs1a[d]), 288'(instr[19:15]));
            chk("rs2_addr", 288'(rs2a[d]), 288'(instr[24:20]));
            if (rst) begin
                chk("reset_ex", 288'(got[d]), 288'd0);
            end else if (m_valid[d]) begin
                if (sbq[d].size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_empty: dut %0d shows valid_ex with nothing expected", d);
                end else begin
                    chk("ex_data", 288'(got[d]), 288'(sbq[d][0]));
                    if (ready_ex) void'(sbq[d].pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] ri;
        #1 rst = 1'b1;
        repeat (3) drive(1'b1, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        drive(1'b0, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd7, 64'd9);
        drive(1'b0, 32'h0000A103, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'h100, 64'd0);
        drive(1'b0, 32'h001101B3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd3, 64'd4);
        drive(1'b0, 32'h001101B3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd3, 64'd4);
        drive(1'b0, 32'h00002003, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        drive(1'b0, 32'hFE000EE3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd5, 64'd6);
        drive(1'b0, 32'h000081B3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 64'h1234, 64'd0, 64'd0);
        drive(1'b0, 32'h000001B3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 64'h1234, 64'd0, 64'd0);
        drive(1'b0, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        drive(1'b0, 32'h003100BB, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd1, 64'd2);
        drive(1'b0, 32'h003100BB, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 64'd1, 64'd2);
        drive(1'b0, 32'h003100BB, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd1, 64'd2);
        drive(1'b0, 32'h003100BB, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd1, 64'd2);
        drive(1'b0, 32'h00000013, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        for (int c = 0; c < 600; c++) begin
            ri = $urandom;
            ri[6:0]   = OPS[$urandom_range(0, 11)];
            ri[11:7]  = 5'($urandom_range(0, 3));
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            drive((c == 300) || (c == 301), ri,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
        end
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
